// File: rtl/accum_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// coproc_accum_pkg
// Shared types and default geometry for the image coprocessor's
// row-accumulation path.
//   accum_state_t : sequencing states of accum_ctrl
//   IMG_COLS      : pixels per row (matches data_accum capacity)
//   IMG_ROWS      : rows per frame
//   PIX_W         : pixel width in bits
//   ROW_W         : width of one packed row as written to the row buffer
// ---------------------------------------------------------------------------
package coproc_accum_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } accum_state_t;

    localparam int IMG_COLS = 256;
    localparam int IMG_ROWS = 256;
    localparam int PIX_W    = 12;
    localparam int ROW_W    = IMG_COLS * PIX_W;

endpackage

// File: rtl/accum_ctrl_if.sv
// ---------------------------------------------------------------------------
// accum_ctrl_if
// Bundles the pixel handshake, the data_accum control strobes and the
// row-buffer write handshake that accum_ctrl sequences.
//   pix_valid   : source has a pixel
//   pix_ready   : controller accepts a pixel this cycle
//   accum_start : clears the data_accum row
//   accum_we    : data_accum write enable
//   col_cnt     : column of the current pixel
//   row_we      : row-buffer write request
//   row_addr    : row-buffer address
//   row_ack     : row buffer accepted the write
// Modports: master = the controller, slave = source / data_accum / row buffer.
// ---------------------------------------------------------------------------
interface accum_ctrl_if #(
    parameter int CW = 8,
    parameter int RW = 8
);
    logic          pix_valid;
    logic          pix_ready;
    logic          accum_start;
    logic          accum_we;
    logic [CW-1:0] col_cnt;
    logic          row_we;
    logic [RW-1:0] row_addr;
    logic          row_ack;

    modport master (
        input  pix_valid,
        input  row_ack,
        output pix_ready,
        output accum_start,
        output accum_we,
        output col_cnt,
        output row_we,
        output row_addr
    );

    modport slave (
        output pix_valid,
        output row_ack,
        input  pix_ready,
        input  accum_start,
        input  accum_we,
        input  col_cnt,
        input  row_we,
        input  row_addr
    );
endinterface

// File: rtl/accum_ctrl.sv
// ---------------------------------------------------------------------------
// accum_ctrl
// Sequences data_accum through one frame: for each row it clears the
// accumulator, streams COLS pixels into it, then issues one row-buffer write
// and waits for its acknowledge. A one-cycle frame_done follows the last row.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   frame_start  : frame request, honoured only when idle
//   abort        : synchronous abort back to idle, counters cleared
//   bus          : pixel / data_accum / row-buffer signals (master side)
//   busy         : high whenever not idle
//   frame_done   : one-cycle pulse after the last row is acknowledged
// ---------------------------------------------------------------------------
module accum_ctrl
    import coproc_accum_pkg::*;
#(
    parameter int COLS = IMG_COLS,
    parameter int ROWS = IMG_ROWS,
    parameter int CW   = 8,
    parameter int RW   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_start,
    input  logic          abort,
    accum_ctrl_if.master  bus,
    output logic          busy,
    output logic          frame_done
);

    // Wrap points are explicit compares so non-power-of-2 geometries work.
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    accum_state_t  state;
    accum_state_t  state_nxt;
    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic          pix_fire;

    // pix_ready is asserted for the whole ACCUM state, so a pixel is taken
    // whenever the source is valid there.
    assign pix_fire = (state == ACCUM) && bus.pix_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (frame_start) state_nxt = CLEAR;
                CLEAR:   state_nxt = ACCUM;
                ACCUM:   if (pix_fire && (col_cnt == COL_LAST)) state_nxt = WRITE;
                WRITE:   if (bus.row_ack) state_nxt = (row_cnt == ROW_LAST) ? DONE : CLEAR;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Column and row counters. row_cnt advances on the acknowledging edge so
    // row_addr stays stable for the whole write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (abort) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else begin
            if (pix_fire) begin
                col_cnt <= (col_cnt == COL_LAST) ? '0 : col_cnt + CW'(1);
            end
            if (state == IDLE) begin
                row_cnt <= '0;
            end else if ((state == WRITE) && bus.row_ack && (row_cnt != ROW_LAST)) begin
                row_cnt <= row_cnt + RW'(1);
            end
        end
    end

    // Moore decode from the state register; accum_we alone follows pix_valid
    // combinationally so a pixel lands in data_accum on the accepting edge.
    always_comb begin
        bus.pix_ready   = 1'b0;
        bus.accum_start = 1'b0;
        bus.accum_we    = 1'b0;
        bus.row_we      = 1'b0;
        frame_done      = 1'b0;
        busy            = (state != IDLE);
        case (state)
            CLEAR: bus.accum_start = 1'b1;
            ACCUM: begin
                bus.pix_ready = 1'b1;
                bus.accum_we  = bus.pix_valid;
            end
            WRITE: bus.row_we = 1'b1;
            DONE:  frame_done = 1'b1;
            default: ;
        endcase
    end

    assign bus.col_cnt  = col_cnt;
    assign bus.row_addr = row_cnt;

endmodule

// File: tb/tb_accum_ctrl.sv
// ---------------------------------------------------------------------------
// tb_accum_ctrl
// Random pixel streams are pushed as expected rows into a scoreboard; a
// negedge monitor models data_accum (pixel k lands at column col_cnt) and
// compares each row write and frame_done against the queued expectations.
// ---------------------------------------------------------------------------
module tb_accum_ctrl;
    import coproc_accum_pkg::*;

    localparam int COLS = 256;
    localparam int ROWS = 3;
    localparam int CW   = 8;
    localparam int RW   = 2;
    localparam int PW   = PIX_W;

    logic          clk         = 1'b0;
    logic          rst_n       = 1'b0;
    logic          frame_start = 1'b0;
    logic          abort       = 1'b0;
    logic          busy;
    logic          frame_done;
    logic [PW-1:0] pix_data    = '0;

    accum_ctrl_if #(.CW(CW), .RW(RW)) bus ();

    accum_ctrl #(.COLS(COLS), .ROWS(ROWS), .CW(CW), .RW(RW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .abort       (abort),
        .bus         (bus),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scoreboard queues: expected row addresses, row pixels (COLS per row),
    // and expected frame_done pulses.
    int exp_addr[$];
    int exp_pix[$];
    int exp_done[$];

    int ack_delay = 0;
    bit ack_tie   = 1'b0;
    int fs_req    = 0;
    int fs_done   = 0;

    int clears    = 0;
    int cyc       = 0;
    int clear_cyc[$];
    int done_cyc  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // frame_start driver: one high cycle per outstanding request.
    always @(posedge clk) begin
        #1;
        if (fs_done < fs_req) begin
            frame_start = 1'b1;
            fs_done++;
        end else begin
            frame_start = 1'b0;
        end
    end

    // Row buffer: acknowledges in the (ack_delay+1)-th write cycle, or ties
    // row_ack high permanently when ack_tie is set.
    int wcnt = 0;
    always @(posedge clk) begin
        #1;
        if (bus.row_we) begin
            bus.row_ack = ack_tie || (wcnt >= ack_delay);
            wcnt++;
        end else begin
            bus.row_ack = ack_tie;
            wcnt = 0;
        end
    end

    // Monitor
    int cap[COLS];
    int nwe      = 0;
    int wlen     = 0;
    int waddr    = 0;
    bit in_write = 1'b0;
    bit prev_clr = 1'b0;
    int mon_ea   = 0;
    int mon_nbad = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            nwe      = 0;
            wlen     = 0;
            in_write = 1'b0;
            prev_clr = 1'b0;
        end else begin
            cyc++;
            if (prev_clr) check("first_ready", bus.pix_ready, 1);
            if (bus.accum_start) begin
                clears++;
                clear_cyc.push_back(cyc);
                nwe = 0;
                for (int k = 0; k < COLS; k++) cap[k] = -1;
            end
            if (bus.accum_we && !abort) begin
                cap[bus.col_cnt] = int'(pix_data);
                nwe++;
            end
            if (bus.row_we) begin
                if (!in_write) begin
                    in_write = 1'b1;
                    wlen     = 0;
                    waddr    = int'(bus.row_addr);
                    if (exp_addr.size() == 0 || exp_pix.size() < COLS) begin
                        check("row_unexpected", 1, 0);
                    end else begin
                        mon_ea = exp_addr.pop_front();
                        check("row_addr", bus.row_addr, mon_ea);
                        check("row_pixel_count", nwe, COLS);
                        mon_nbad = 0;
                        for (int k = 0; k < COLS; k++) begin
                            if (cap[k] != exp_pix.pop_front()) mon_nbad++;
                        end
                        check("row_data_bad_slices", mon_nbad, 0);
                    end
                end
                wlen++;
                check("write_hold", (bus.pix_ready == 1'b0) && (bus.col_cnt == '0) &&
                      (int'(bus.row_addr) == waddr), 1);
            end else if (in_write) begin
                in_write = 1'b0;
                check("write_len", wlen, ack_tie ? 1 : ack_delay + 1);
            end
            if (frame_done) begin
                done_cyc = cyc;
                if (exp_done.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    void'(exp_done.pop_front());
                    check("done_busy", busy, 1);
                end
            end
            if (abort) in_write = 1'b0;
            prev_clr = bus.accum_start;
        end
    end

    // Call aligned anywhere; frame_start is sampled two negedges later.
    task automatic start_frame(input int hold);
        @(negedge clk);
        fs_req += hold;
        @(negedge clk);
        check("clear_early", bus.accum_start, 0);
        @(negedge clk);
        check("clear_latency", bus.accum_start, 1);
        check("clear_ready", bus.pix_ready, 0);
    endtask

    task automatic send_row(input int r, input int duty, input int abort_at, output bit stopped);
        int px[COLS];
        int idx;
        int guard;
        for (int k = 0; k < COLS; k++) px[k] = int'($urandom_range(0, 4095));
        idx     = 0;
        guard   = 0;
        stopped = 1'b0;
        while (idx < COLS) begin
            @(posedge clk);
            #1;
            if (idx == abort_at) begin
                check("col_at_abort", bus.col_cnt, abort_at);
                abort         = 1'b1;
                bus.pix_valid = 1'b0;
                @(posedge clk);
                #1 abort = 1'b0;
                @(negedge clk);
                check("abort_busy", busy, 0);
                check("abort_col", bus.col_cnt, 0);
                check("abort_row_addr", bus.row_addr, 0);
                check("abort_ready", bus.pix_ready, 0);
                stopped = 1'b1;
                return;
            end
            bus.pix_valid = ($urandom_range(1, 100) <= duty);
            pix_data      = PW'(px[idx]);
            @(negedge clk);
            if (bus.pix_valid && bus.pix_ready) idx++;
            guard++;
            if (guard > 40 * COLS) begin
                check("row_timeout", 0, 1);
                stopped = 1'b1;
                return;
            end
        end
        exp_addr.push_back(r);
        for (int k = 0; k < COLS; k++) exp_pix.push_back(px[k]);
    endtask

    task automatic wait_idle(input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (!busy) seen = 1'b1;
        end
        check("idle_timeout", seen, 1);
    endtask

    task automatic run_frame(input int hold, input int duty, input int delay,
                             input int abort_row, input int abort_at,
                             input int busy_fs_row, input bit tie);
        int n0;
        bit stop;
        ack_delay = delay;
        ack_tie   = tie;
        n0        = clears;
        start_frame(hold);
        for (int r = 0; r < ROWS; r++) begin
            if (r == busy_fs_row) fs_req += 1;
            send_row(r, duty, (r == abort_row) ? abort_at : -1, stop);
            if (stop) begin
                bus.pix_valid = 1'b0;
                return;
            end
        end
        exp_done.push_back(1);
        wait_idle(100 + 4 * delay);
        bus.pix_valid = 1'b0;
        check("frame_clears", clears - n0, ROWS);
        if (duty == 100 && delay == 0) begin
            for (int r = 1; r < ROWS; r++) begin
                check("row_period", clear_cyc[n0 + r] - clear_cyc[n0 + r - 1], COLS + 2);
            end
            check("frame_len", done_cyc - clear_cyc[n0], ROWS * (COLS + 2));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit stop;
        bit seen;
        bus.pix_valid = 1'b1;
        #12;
        check("rst_pix_ready", bus.pix_ready, 0);
        check("rst_accum_start", bus.accum_start, 0);
        check("rst_accum_we", bus.accum_we, 0);
        check("rst_row_we", bus.row_we, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_col_cnt", bus.col_cnt, 0);
        check("rst_row_addr", bus.row_addr, 0);
        bus.pix_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back rows, row_ack tied high (also outside WRITE).
        run_frame(1, 100, 0, -1, -1, -1, 1'b1);
        // Random gaps in pix_valid.
        run_frame(1, 50, 0, -1, -1, -1, 1'b0);
        // Delayed acknowledge: five write cycles per row.
        run_frame(1, 60, 4, -1, -1, -1, 1'b0);
        // Abort at column 100 of row 1, then a clean restart from row 0.
        run_frame(1, 100, 0, 1, 100, -1, 1'b0);
        run_frame(1, 70, 0, -1, -1, -1, 1'b0);

        // Reset in the middle of row 1's write.
        ack_delay = 10;
        ack_tie   = 1'b0;
        start_frame(1);
        send_row(0, 100, -1, stop);
        send_row(1, 100, -1, stop);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (bus.row_we) seen = 1'b1;
        end
        check("reset_write_seen", seen, 1);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_pix_ready", bus.pix_ready, 0);
        check("async_accum_we", bus.accum_we, 0);
        check("async_row_we", bus.row_we, 0);
        check("async_busy", busy, 0);
        check("async_row_addr", bus.row_addr, 0);
        check("async_col_cnt", bus.col_cnt, 0);
        bus.pix_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Frame after reset with a stray frame_start while busy.
        run_frame(1, 80, 2, -1, -1, 1, 1'b0);
        // frame_start held for three cycles.
        run_frame(3, 100, 0, -1, -1, -1, 1'b0);

        repeat (5) @(negedge clk);
        check("rows_pending", exp_addr.size(), 0);
        check("done_pending", exp_done.size(), 0);
        check("end_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
